// File: rtl/image_pkg.sv
// ---------------------------------------------------------------------------
// image_pkg
// Shared frame/block geometry for the image pipeline, the block-fetch FSM
// state type, and the helper that turns a block coordinate into the pixel
// coordinate of the block's top-left corner.
// ---------------------------------------------------------------------------
package image_pkg;

  localparam int FRAME_DIM       = 240;
  localparam int BLOCK_DIM       = 4;
  localparam int BLOCKS_PER_SIDE = 60;
  localparam int PIXEL_W         = 9;

  // Largest legal block coordinate along either axis.
  localparam int MAX_BLOCK_COORD = BLOCKS_PER_SIDE - 1;

  // One spare bit above the frame size so an out-of-range 7-bit block
  // coordinate still forms its full 4*b origin without wrapping.
  localparam int ADDR_W = $clog2(FRAME_DIM) + 1;

  localparam int BLOCK_PIXELS = BLOCK_DIM * BLOCK_DIM;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } fetch_state_t;

  // 4*b formed by shifting the low 7 bits of the coordinate.
  function automatic logic [ADDR_W-1:0] blockOrigin(input logic [6:0] b);
    return {b, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_tag_pipe.sv
// ---------------------------------------------------------------------------
// fetch_tag_pipe
// Delay line that carries a valid bit and a 4-bit pixel index alongside an
// outstanding memory read, so the tag pops out in the same cycle the read
// data arrives.
//
// Ports:
//   clk       - rising-edge clock
//   reset_n   - synchronous active-low reset, empties the line
//   i_valid   - an address is being issued this cycle
//   i_index   - pixel index (0..15) of that address
//   o_valid   - valid bit delayed by DEPTH cycles
//   o_index   - index delayed by DEPTH cycles
// ---------------------------------------------------------------------------
module fetch_tag_pipe #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_valid,
  input  logic [3:0] i_index,
  output logic       o_valid,
  output logic [3:0] o_index
);

  logic [DEPTH-1:0] r_valid;
  logic [3:0]       r_index [DEPTH];

  // Plain shift register; clearing the valid bits on reset discards any
  // reads still in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_index[k] <= '0;
      end
    end else begin
      r_valid[0] <= i_valid;
      r_index[0] <= i_index;
      for (int k = 1; k < DEPTH; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_index[k] <= r_index[k-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_index = r_index[DEPTH-1];

endmodule

// File: rtl/block_pixel_fetch.sv
// ---------------------------------------------------------------------------
// block_pixel_fetch
// Reads one 4x4 pixel block from frame memory. On an accepted start the
// block coordinate is latched, 16 pixel addresses are issued on consecutive
// cycles in raster order, the returning data is collected in working
// registers, and the whole block is published on pixel_0..pixel_f together
// with a one-cycle done pulse. The published pixels stay put until the next
// done pulse.
//
// Ports:
//   clk, reset_n            - clock and synchronous active-low reset
//   start                   - fetch request, only looked at in IDLE
//   block_x, block_y        - block coordinate (0..59)
//   mem_pixel_data          - read data, MEM_LATENCY cycles after its address
//   mem_request             - address valid this cycle
//   mem_hcount, mem_vcount  - pixel address
//   busy                    - fetch in progress
//   done                    - one-cycle completion pulse
//   range_err               - latched coordinate was out of range
//   pixel_0..pixel_f        - block pixels, index = 4*row + col
//
// Build option: define BLOCK_FETCH_CLAMP_EN to clamp coordinates above 59
// to 59 and flag range_err; otherwise coordinates are used as given and
// range_err stays low.
// ---------------------------------------------------------------------------
module block_pixel_fetch
  import image_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [7:0]         block_x,
  input  logic [7:0]         block_y,
  input  logic [PIXEL_W-1:0] mem_pixel_data,
  output logic               mem_request,
  output logic [ADDR_W-1:0]  mem_hcount,
  output logic [ADDR_W-1:0]  mem_vcount,
  output logic               busy,
  output logic               done,
  output logic               range_err,
  output logic [PIXEL_W-1:0] pixel_0,
  output logic [PIXEL_W-1:0] pixel_1,
  output logic [PIXEL_W-1:0] pixel_2,
  output logic [PIXEL_W-1:0] pixel_3,
  output logic [PIXEL_W-1:0] pixel_4,
  output logic [PIXEL_W-1:0] pixel_5,
  output logic [PIXEL_W-1:0] pixel_6,
  output logic [PIXEL_W-1:0] pixel_7,
  output logic [PIXEL_W-1:0] pixel_8,
  output logic [PIXEL_W-1:0] pixel_9,
  output logic [PIXEL_W-1:0] pixel_a,
  output logic [PIXEL_W-1:0] pixel_b,
  output logic [PIXEL_W-1:0] pixel_c,
  output logic [PIXEL_W-1:0] pixel_d,
  output logic [PIXEL_W-1:0] pixel_e,
  output logic [PIXEL_W-1:0] pixel_f
);

  fetch_state_t       r_state;
  logic               r_memRequest;
  logic [ADDR_W-1:0]  r_memHcount;
  logic [ADDR_W-1:0]  r_memVcount;
  logic [ADDR_W-1:0]  r_baseX;
  logic [ADDR_W-1:0]  r_baseY;
  logic [3:0]         r_issueIdx;
  logic               r_busy;
  logic               r_done;
  logic               r_rangeErr;
  logic [PIXEL_W-1:0] r_work  [BLOCK_PIXELS];
  logic [PIXEL_W-1:0] r_pixel [BLOCK_PIXELS];

  logic               w_tagValid;
  logic [3:0]         w_tagIdx;
  logic [3:0]         w_nextIdx;
  logic [7:0]         w_latchX;
  logic [7:0]         w_latchY;
  logic               w_rangeHit;
  logic               w_unused;

`ifdef BLOCK_FETCH_CLAMP_EN
  assign w_latchX   = (block_x > 8'(MAX_BLOCK_COORD)) ? 8'(MAX_BLOCK_COORD) : block_x;
  assign w_latchY   = (block_y > 8'(MAX_BLOCK_COORD)) ? 8'(MAX_BLOCK_COORD) : block_y;
  assign w_rangeHit = (block_x > 8'(MAX_BLOCK_COORD)) || (block_y > 8'(MAX_BLOCK_COORD));
`else
  assign w_latchX   = block_x;
  assign w_latchY   = block_y;
  assign w_rangeHit = 1'b0;
`endif

  // Bit 7 of a coordinate drops out of the 4*b origin by design.
  assign w_unused  = w_latchX[7] ^ w_latchY[7];

  assign w_nextIdx = r_issueIdx + 4'd1;

  // The tag pipe is fed from the registered request/index, so its output
  // lines up with the data for the address that was on the bus DEPTH
  // cycles earlier.
  fetch_tag_pipe #(
    .DEPTH(MEM_LATENCY)
  ) u_tagPipe (
    .clk    (clk),
    .reset_n(reset_n),
    .i_valid(r_memRequest),
    .i_index(r_issueIdx),
    .o_valid(w_tagValid),
    .o_index(w_tagIdx)
  );

  // Returning read data lands in its working slot whenever a tag emerges.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < BLOCK_PIXELS; k++) begin
        r_work[k] <= '0;
      end
    end else if (w_tagValid) begin
      r_work[w_tagIdx] <= mem_pixel_data;
    end
  end

  // Fetch FSM. The address for the next index is registered one cycle
  // ahead so the bus shows index i exactly while that index is current.
  // On leaving DRAIN the last pixel is still on mem_pixel_data, so it is
  // published straight from the bus rather than from its working slot.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_memRequest <= 1'b0;
      r_memHcount  <= '0;
      r_memVcount  <= '0;
      r_baseX      <= '0;
      r_baseY      <= '0;
      r_issueIdx   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_rangeErr   <= 1'b0;
      for (int k = 0; k < BLOCK_PIXELS; k++) begin
        r_pixel[k] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state      <= ISSUE;
            r_busy       <= 1'b1;
            r_memRequest <= 1'b1;
            r_issueIdx   <= '0;
            r_baseX      <= blockOrigin(w_latchX[6:0]);
            r_baseY      <= blockOrigin(w_latchY[6:0]);
            r_memHcount  <= blockOrigin(w_latchX[6:0]);
            r_memVcount  <= blockOrigin(w_latchY[6:0]);
            r_rangeErr   <= w_rangeHit;
          end
        end
        ISSUE: begin
          if (r_issueIdx == 4'hF) begin
            r_state      <= DRAIN;
            r_memRequest <= 1'b0;
          end else begin
            r_issueIdx  <= w_nextIdx;
            r_memHcount <= r_baseX + {{(ADDR_W-2){1'b0}}, w_nextIdx[1:0]};
            r_memVcount <= r_baseY + {{(ADDR_W-2){1'b0}}, w_nextIdx[3:2]};
          end
        end
        DRAIN: begin
          if (w_tagValid && (w_tagIdx == 4'hF)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            for (int k = 0; k < BLOCK_PIXELS - 1; k++) begin
              r_pixel[k] <= r_work[k];
            end
            r_pixel[BLOCK_PIXELS-1] <= mem_pixel_data;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_request = r_memRequest;
  assign mem_hcount  = r_memHcount;
  assign mem_vcount  = r_memVcount;
  assign busy        = r_busy;
  assign done        = r_done;
  assign range_err   = r_rangeErr;

  assign pixel_0 = r_pixel[0];
  assign pixel_1 = r_pixel[1];
  assign pixel_2 = r_pixel[2];
  assign pixel_3 = r_pixel[3];
  assign pixel_4 = r_pixel[4];
  assign pixel_5 = r_pixel[5];
  assign pixel_6 = r_pixel[6];
  assign pixel_7 = r_pixel[7];
  assign pixel_8 = r_pixel[8];
  assign pixel_9 = r_pixel[9];
  assign pixel_a = r_pixel[10];
  assign pixel_b = r_pixel[11];
  assign pixel_c = r_pixel[12];
  assign pixel_d = r_pixel[13];
  assign pixel_e = r_pixel[14];
  assign pixel_f = r_pixel[15];

endmodule

// File: tb/tb_block_pixel_fetch.sv
// ---------------------------------------------------------------------------
// tb_block_pixel_fetch
// Two instances share clock and reset: dut with MEM_LATENCY=2 and dutSlow
// with MEM_LATENCY=5. Each has a frame-memory model that returns
// hcount+vcount MEM_LATENCY cycles after a requested address (and an
// impossible value 511 for cycles with no request).
// Cycle numbering: the cycle in which start is held high is cycle 0; the
// bench advances one cycle per tick and looks at outputs 1 time unit after
// the rising edge.
// ---------------------------------------------------------------------------
module tb_block_pixel_fetch;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, startS;
  logic [7:0] bx, by, bxS, byS;
  logic [8:0] memData, memDataS;
  logic       req, reqS;
  logic [8:0] hc, vc, hcS, vcS;
  logic       busy, done, rangeErr;
  logic       busyS, doneS, rangeErrS;
  logic [8:0] px  [16];
  logic [8:0] pxS [16];
  logic [8:0] prevPix  [16];
  logic [8:0] prevPixS [16];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  block_pixel_fetch #(.MEM_LATENCY(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .block_x(bx), .block_y(by), .mem_pixel_data(memData),
    .mem_request(req), .mem_hcount(hc), .mem_vcount(vc),
    .busy(busy), .done(done), .range_err(rangeErr),
    .pixel_0(px[0]), .pixel_1(px[1]), .pixel_2(px[2]), .pixel_3(px[3]),
    .pixel_4(px[4]), .pixel_5(px[5]), .pixel_6(px[6]), .pixel_7(px[7]),
    .pixel_8(px[8]), .pixel_9(px[9]), .pixel_a(px[10]), .pixel_b(px[11]),
    .pixel_c(px[12]), .pixel_d(px[13]), .pixel_e(px[14]), .pixel_f(px[15])
  );

  block_pixel_fetch #(.MEM_LATENCY(5)) dutSlow (
    .clk(clk), .reset_n(reset_n), .start(startS),
    .block_x(bxS), .block_y(byS), .mem_pixel_data(memDataS),
    .mem_request(reqS), .mem_hcount(hcS), .mem_vcount(vcS),
    .busy(busyS), .done(doneS), .range_err(rangeErrS),
    .pixel_0(pxS[0]), .pixel_1(pxS[1]), .pixel_2(pxS[2]), .pixel_3(pxS[3]),
    .pixel_4(pxS[4]), .pixel_5(pxS[5]), .pixel_6(pxS[6]), .pixel_7(pxS[7]),
    .pixel_8(pxS[8]), .pixel_9(pxS[9]), .pixel_a(pxS[10]), .pixel_b(pxS[11]),
    .pixel_c(pxS[12]), .pixel_d(pxS[13]), .pixel_e(pxS[14]), .pixel_f(pxS[15])
  );

  // Frame memory models: fixed-latency shift registers of hcount+vcount.
  logic [8:0] memPipe  [2];
  logic [8:0] memPipeS [5];

  always @(posedge clk) begin
    memPipe[0] <= req ? (hc + vc) : 9'h1FF;
    memPipe[1] <= memPipe[0];
  end
  assign memData = memPipe[1];

  always @(posedge clk) begin
    memPipeS[0] <= reqS ? (hcS + vcS) : 9'h1FF;
    for (int k = 1; k < 5; k++) memPipeS[k] <= memPipeS[k-1];
  end
  assign memDataS = memPipeS[4];

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0; bx = 8'd0; by = 8'd0;
    startS = 1'b0; bxS = 8'd0; byS = 8'd0;
    for (int k = 0; k < 16; k++) begin
      prevPix[k] = 9'd0;
      prevPixS[k] = 9'd0;
    end
    tick(); tick(); tick();
    total++; if (req !== 1'b0)      begin bad++; $display("[TB] FAIL reset_req: got %0b want 0", req); end
    total++; if (done !== 1'b0)     begin bad++; $display("[TB] FAIL reset_done: got %0b want 0", done); end
    total++; if (busy !== 1'b0)     begin bad++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
    total++; if (rangeErr !== 1'b0) begin bad++; $display("[TB] FAIL reset_rangeErr: got %0b want 0", rangeErr); end
    total++; if (hc !== 9'd0 || vc !== 9'd0) begin bad++; $display("[TB] FAIL reset_addr: got %0d,%0d want 0,0", hc, vc); end
    total++; if (reqS !== 1'b0 || busyS !== 1'b0 || doneS !== 1'b0 || rangeErrS !== 1'b0)
      begin bad++; $display("[TB] FAIL reset_slow_ctrl: got %0b%0b%0b%0b want 0000", reqS, busyS, doneS, rangeErrS); end
    for (int k = 0; k < 16; k++) begin
      total++; if (px[k] !== 9'd0) begin bad++; $display("[TB] FAIL reset_pixel%0d: got %0d want 0", k, px[k]); end
    end
    reset_n = 1'b1;
    tick();
  endtask

  // Full fetches of hand-picked blocks on the latency-2 instance, checking
  // every address, the done/busy timing and the published pixels.
  task automatic test_fetch_vectors();
    logic [7:0] vx [3];
    logic [7:0] vy [3];
    logic [8:0] vbx [3];
    logic [8:0] vby [3];
    logic       vErr [3];
    logic [3:0] idx;
    logic [8:0] expH, expV, expP;
    vx[0] = 8'd0;  vy[0] = 8'd0;  vbx[0] = 9'd0;   vby[0] = 9'd0;   vErr[0] = 1'b0;
`ifdef BLOCK_FETCH_CLAMP_EN
    vx[1] = 8'd63; vy[1] = 8'd0;  vbx[1] = 9'd236; vby[1] = 9'd0;   vErr[1] = 1'b1;
`else
    vx[1] = 8'd63; vy[1] = 8'd0;  vbx[1] = 9'd252; vby[1] = 9'd0;   vErr[1] = 1'b0;
`endif
    vx[2] = 8'd59; vy[2] = 8'd59; vbx[2] = 9'd236; vby[2] = 9'd236; vErr[2] = 1'b0;
    for (int v = 0; v < 3; v++) begin
      start = 1'b1; bx = vx[v]; by = vy[v];
      tick();
      start = 1'b0;
      for (int c = 1; c <= 20; c++) begin
        idx  = (c <= 16) ? 4'(c - 1) : 4'hF;
        expH = vbx[v] + {7'd0, idx[1:0]};
        expV = vby[v] + {7'd0, idx[3:2]};
        total++; if (req !== (c <= 16))
          begin bad++; $display("[TB] FAIL v%0d_req c%0d: got %0b want %0b", v, c, req, (c <= 16)); end
        total++; if (hc !== expH || vc !== expV)
          begin bad++; $display("[TB] FAIL v%0d_addr c%0d: got %0d,%0d want %0d,%0d", v, c, hc, vc, expH, expV); end
        total++; if (done !== (c == 19))
          begin bad++; $display("[TB] FAIL v%0d_done c%0d: got %0b want %0b", v, c, done, (c == 19)); end
        total++; if (busy !== (c <= 19))
          begin bad++; $display("[TB] FAIL v%0d_busy c%0d: got %0b want %0b", v, c, busy, (c <= 19)); end
        total++; if (rangeErr !== vErr[v])
          begin bad++; $display("[TB] FAIL v%0d_rangeErr c%0d: got %0b want %0b", v, c, rangeErr, vErr[v]); end
        if (c == 19) begin
          for (int k = 0; k < 16; k++) begin
            expP = vbx[v] + vby[v] + 9'(k % 4) + 9'(k / 4);
            total++; if (px[k] !== expP)
              begin bad++; $display("[TB] FAIL v%0d_pixel%0d: got %0d want %0d", v, k, px[k], expP); end
            prevPix[k] = expP;
          end
        end else if (c < 19) begin
          total++; if (px[0] !== prevPix[0] || px[15] !== prevPix[15])
            begin bad++; $display("[TB] FAIL v%0d_hold c%0d: got %0d,%0d want %0d,%0d", v, c, px[0], px[15], prevPix[0], prevPix[15]); end
        end
        if (c < 20) tick();
      end
    end
  endtask

  // Start re-pulsed mid-fetch and during done: only one fetch may run.
  task automatic test_restart();
    int doneCnt, reqCnt, doneCycle;
    doneCnt = 0; reqCnt = 0; doneCycle = -1;
    start = 1'b1; bx = 8'd1; by = 8'd1;
    tick();
    for (int c = 1; c <= 30; c++) begin
      if (done === 1'b1) begin doneCnt++; doneCycle = c; end
      if (req === 1'b1) reqCnt++;
      start = (c == 5 || c == 19);
      tick();
    end
    start = 1'b0;
    total++; if (doneCnt != 1)    begin bad++; $display("[TB] FAIL restart_doneCount: got %0d want 1", doneCnt); end
    total++; if (doneCycle != 19) begin bad++; $display("[TB] FAIL restart_doneCycle: got %0d want 19", doneCycle); end
    total++; if (reqCnt != 16)    begin bad++; $display("[TB] FAIL restart_reqCount: got %0d want 16", reqCnt); end
    total++; if (busy !== 1'b0)   begin bad++; $display("[TB] FAIL restart_idle: got %0b want 0", busy); end
    total++; if (px[0] !== 9'd8 || px[15] !== 9'd14)
      begin bad++; $display("[TB] FAIL restart_pixels: got %0d,%0d want 8,14", px[0], px[15]); end
  endtask

  // Reset at cycle 8 of a fetch, then a clean fetch of block (1,2).
  task automatic test_reset_mid_fetch();
    int doneCnt, doneCycle;
    doneCnt = 0; doneCycle = -1;
    start = 1'b1; bx = 8'd2; by = 8'd3;
    tick();
    start = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    total++; if (req !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || rangeErr !== 1'b0)
      begin bad++; $display("[TB] FAIL midreset_ctrl: got %0b%0b%0b%0b want 0000", req, done, busy, rangeErr); end
    total++; if (hc !== 9'd0 || vc !== 9'd0)
      begin bad++; $display("[TB] FAIL midreset_addr: got %0d,%0d want 0,0", hc, vc); end
    for (int k = 0; k < 16; k++) begin
      total++; if (px[k] !== 9'd0) begin bad++; $display("[TB] FAIL midreset_pixel%0d: got %0d want 0", k, px[k]); end
    end
    for (int c = 9; c <= 30; c++) begin
      if (done === 1'b1 || busy === 1'b1) doneCnt++;
      tick();
    end
    total++; if (doneCnt != 0) begin bad++; $display("[TB] FAIL midreset_stale: got %0d want 0", doneCnt); end
    start = 1'b1; bx = 8'd1; by = 8'd2;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (done === 1'b1) begin doneCycle = c; break; end
      tick();
    end
    total++; if (doneCycle != 19) begin bad++; $display("[TB] FAIL midreset_doneCycle: got %0d want 19", doneCycle); end
    total++; if (px[0] !== 9'd12) begin bad++; $display("[TB] FAIL midreset_pixel0: got %0d want 12", px[0]); end
    total++; if (px[5] !== 9'd14) begin bad++; $display("[TB] FAIL midreset_pixel5: got %0d want 14", px[5]); end
    total++; if (px[15] !== 9'd18) begin bad++; $display("[TB] FAIL midreset_pixelF: got %0d want 18", px[15]); end
    tick();
  endtask

  // Two back-to-back fetches on the latency-5 instance.
  task automatic test_back_to_back();
    logic [7:0] fx [2];
    logic [7:0] fy [2];
    logic [8:0] fbase [2];
    logic [8:0] expP;
    fx[0] = 8'd5;  fy[0] = 8'd7; fbase[0] = 9'd48;
    fx[1] = 8'd10; fy[1] = 8'd3; fbase[1] = 9'd52;
    for (int f = 0; f < 2; f++) begin
      startS = 1'b1; bxS = fx[f]; byS = fy[f];
      tick();
      startS = 1'b0;
      for (int c = 1; c <= 23; c++) begin
        total++; if (doneS !== (c == 22))
          begin bad++; $display("[TB] FAIL b2b%0d_done c%0d: got %0b want %0b", f, c, doneS, (c == 22)); end
        total++; if (busyS !== (c <= 22) || reqS !== (c <= 16))
          begin bad++; $display("[TB] FAIL b2b%0d_busyReq c%0d: got %0b%0b want %0b%0b", f, c, busyS, reqS, (c <= 22), (c <= 16)); end
        if (c < 22) begin
          total++; if (pxS[0] !== prevPixS[0] || pxS[6] !== prevPixS[6] || pxS[15] !== prevPixS[15])
            begin bad++; $display("[TB] FAIL b2b%0d_hold c%0d: got %0d,%0d,%0d want %0d,%0d,%0d", f, c,
              pxS[0], pxS[6], pxS[15], prevPixS[0], prevPixS[6], prevPixS[15]); end
        end else if (c == 22) begin
          for (int k = 0; k < 16; k++) begin
            expP = fbase[f] + 9'(k % 4) + 9'(k / 4);
            total++; if (pxS[k] !== expP)
              begin bad++; $display("[TB] FAIL b2b%0d_pixel%0d: got %0d want %0d", f, k, pxS[k], expP); end
            prevPixS[k] = expP;
          end
        end
        if (c < 23) tick();
      end
    end
  endtask

  initial begin
    $display("[TB] block_pixel_fetch bench starting");
    test_reset();
    test_fetch_vectors();
    test_restart();
    test_reset_mid_fetch();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
